fcvt_pipe: RTL and testbench

Pipelined, parametrised int↔binary32 converter for the FPU, replacing the combinational single-direction converters. One unit handles both directions (op select) and two rounding modes, with a valid/ready handshake on both sides. Out-of-range and NaN inputs saturate, and inexact/invalid flags are reported. A tag travels with each operation so the issue stage can match results to their destination registers.

---
 rtl/fcvt_pipe.sv | 186 ++++++++++++++++++
 tb/tb_fcvt_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_pipe.sv
`timescale 1ns/1ps
// fcvt_pipe: three-stage signed int <-> binary32 converter (RNE/RTZ) with
// saturation, inexact/invalid flags and a pass-through tag; one global stall enable.
module fcvt_pipe #(
    parameter int INT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             in_rm,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nx,
    output logic             out_nv
);
    localparam logic [1:0] CLS_ZERO = 2'd0, CLS_NORM = 2'd1, CLS_INF = 2'd2, CLS_NAN = 2'd3;
    localparam logic [32:0] POS_MAX = (33'd1 << (INT_W - 1)) - 33'd1;
    localparam logic [32:0] NEG_MAG = 33'd1 << (INT_W - 1);
    localparam logic signed [9:0] EXP_BIG = 10'(INT_W);

    logic adv;

    logic             s1_vld_q, s1_vld_d, s1_op_q, s1_op_d, s1_rm_q, s1_rm_d, s1_sgn_q, s1_sgn_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [31:0]      s1_mag_q, s1_mag_d;
    logic signed [9:0] s1_exp_q, s1_exp_d;
    logic [1:0]       s1_cls_q, s1_cls_d;
    logic [INT_W-1:0] ival, imag;

    logic             s2_vld_q, s2_vld_d, s2_op_q, s2_op_d, s2_rm_q, s2_rm_d, s2_sgn_q, s2_sgn_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [31:0]      s2_mag_q, s2_mag_d;
    logic [7:0]       s2_exp_q, s2_exp_d;
    logic             s2_grd_q, s2_grd_d, s2_stk_q, s2_stk_d, s2_zero_q, s2_zero_d;
    logic             s2_big_q, s2_big_d, s2_nan_q, s2_nan_d;
    logic [31:0]      norm;
    logic [95:0]      wide;
    logic [5:0]       sh;

    logic             out_vld_q, out_vld_d, out_nx_q, out_nx_d, out_nv_q, out_nv_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             inc, ovf;
    logic [24:0]      man_r;
    logic [7:0]       bexp;
    logic [32:0]      rnd;

    assign adv       = ~out_vld_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_nx    = out_nx_q;
    assign out_nv    = out_nv_q;

    // S1: decode. s1_exp holds the leading-one position (itof) or unbiased exponent (ftoi).
    always_comb begin
        s1_vld_d = in_valid;
        s1_op_d  = in_op;
        s1_rm_d  = in_rm;
        s1_tag_d = in_tag;
        ival     = in_data[INT_W-1:0];
        imag     = ival[INT_W-1] ? -ival : ival;
        s1_sgn_d = in_data[31];
        s1_mag_d = {8'h00, |in_data[30:23], in_data[22:0]};
        s1_exp_d = $signed({2'b00, in_data[30:23]}) - 10'sd127;
        s1_cls_d = CLS_NORM;
        if (in_data[30:23] == 8'h00)
            s1_cls_d = CLS_ZERO;
        else if (in_data[30:23] == 8'hFF)
            s1_cls_d = (|in_data[22:0]) ? CLS_NAN : CLS_INF;
        if (!in_op) begin
            s1_sgn_d = ival[INT_W-1];
            s1_mag_d = 32'(imag);
            s1_exp_d = '0;
            for (int i = 0; i < INT_W; i++)
                if (imag[i]) s1_exp_d = 10'(i);
            s1_cls_d = (imag == '0) ? CLS_ZERO : CLS_NORM;
        end
    end

    // S2: align. ftoi places the mantissa so bits [95:64] are the integer part,
    // bit 63 the guard; anything below 0.5 collapses into sticky.
    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_op_d   = s1_op_q;
        s2_rm_d   = s1_rm_q;
        s2_sgn_d  = s1_sgn_q;
        s2_tag_d  = s1_tag_q;
        s2_exp_d  = s1_exp_q[7:0];
        s2_zero_d = (s1_cls_q == CLS_ZERO);
        s2_mag_d  = '0;
        s2_grd_d  = 1'b0;
        s2_stk_d  = 1'b0;
        s2_big_d  = 1'b0;
        s2_nan_d  = 1'b0;
        norm      = s1_mag_q << (5'd31 - s1_exp_q[4:0]);
        sh        = 6'd31 - s1_exp_q[5:0];
        if (s1_exp_q < -10'sd1) sh = 6'd33;
        wide      = {s1_mag_q[23:0], 72'd0} >> sh;
        if (!s1_op_q) begin
            s2_mag_d = norm;
            s2_grd_d = norm[7];
            s2_stk_d = |norm[6:0];
        end else begin
            case (s1_cls_q)
                CLS_ZERO: s2_stk_d = |s1_mag_q;
                CLS_INF:  s2_big_d = 1'b1;
                CLS_NAN:  s2_nan_d = 1'b1;
                default: begin
                    if (s1_exp_q >= EXP_BIG) begin
                        s2_big_d = 1'b1;
                    end else begin
                        s2_mag_d = wide[95:64];
                        s2_grd_d = wide[63];
                        s2_stk_d = |wide[62:0];
                    end
                end
            endcase
        end
    end

    // S3: round, saturate, pack. ftoi overflow is judged on the rounded magnitude.
    always_comb begin
        out_vld_d  = s2_vld_q;
        out_tag_d  = s2_tag_q;
        out_data_d = '0;
        out_nx_d   = 1'b0;
        out_nv_d   = 1'b0;
        inc        = 1'b0;
        ovf        = 1'b0;
        man_r      = '0;
        bexp       = '0;
        rnd        = '0;
        if (!s2_op_q) begin
            inc   = ~s2_rm_q & s2_grd_q & (s2_stk_q | s2_mag_q[8]);
            man_r = {1'b0, s2_mag_q[31:8]} + {24'd0, inc};
            bexp  = s2_exp_q + 8'd127 + {7'd0, man_r[24]};
            if (!s2_zero_q) begin
                out_data_d = {s2_sgn_q, bexp, man_r[24] ? man_r[23:1] : man_r[22:0]};
                out_nx_d   = s2_grd_q | s2_stk_q;
            end
        end else begin
            inc = ~s2_rm_q & s2_grd_q & (s2_stk_q | s2_mag_q[0]);
            rnd = {1'b0, s2_mag_q} + {32'd0, inc};
            ovf = s2_big_q | (s2_sgn_q ? (rnd > NEG_MAG) : (rnd > POS_MAX));
            if (s2_nan_q) begin
                out_data_d = POS_MAX[31:0];
                out_nv_d   = 1'b1;
            end else if (ovf) begin
                out_data_d = s2_sgn_q ? ~POS_MAX[31:0] : POS_MAX[31:0];
                out_nv_d   = 1'b1;
            end else begin
                out_data_d = s2_sgn_q ? -rnd[31:0] : rnd[31:0];
                out_nx_d   = s2_grd_q | s2_stk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld_q <= 1'b0; s1_op_q <= 1'b0; s1_rm_q <= 1'b0; s1_sgn_q <= 1'b0;
            s1_tag_q <= '0; s1_mag_q <= '0; s1_exp_q <= '0; s1_cls_q <= '0;
            s2_vld_q <= 1'b0; s2_op_q <= 1'b0; s2_rm_q <= 1'b0; s2_sgn_q <= 1'b0;
            s2_tag_q <= '0; s2_mag_q <= '0; s2_exp_q <= '0; s2_grd_q <= 1'b0;
            s2_stk_q <= 1'b0; s2_zero_q <= 1'b0; s2_big_q <= 1'b0; s2_nan_q <= 1'b0;
            out_vld_q <= 1'b0; out_data_q <= '0; out_tag_q <= '0;
            out_nx_q <= 1'b0; out_nv_q <= 1'b0;
        end else if (adv) begin
            s1_vld_q <= s1_vld_d; s1_op_q <= s1_op_d; s1_rm_q <= s1_rm_d; s1_sgn_q <= s1_sgn_d;
            s1_tag_q <= s1_tag_d; s1_mag_q <= s1_mag_d; s1_exp_q <= s1_exp_d; s1_cls_q <= s1_cls_d;
            s2_vld_q <= s2_vld_d; s2_op_q <= s2_op_d; s2_rm_q <= s2_rm_d; s2_sgn_q <= s2_sgn_d;
            s2_tag_q <= s2_tag_d; s2_mag_q <= s2_mag_d; s2_exp_q <= s2_exp_d; s2_grd_q <= s2_grd_d;
            s2_stk_q <= s2_stk_d; s2_zero_q <= s2_zero_d; s2_big_q <= s2_big_d; s2_nan_q <= s2_nan_d;
            out_vld_q <= out_vld_d; out_data_q <= out_data_d; out_tag_q <= out_tag_d;
            out_nx_q <= out_nx_d; out_nv_q <= out_nv_d;
        end
    end
endmodule

// File: tb/tb_fcvt_pipe.sv
`timescale 1ns/1ps
// Directed bench for fcvt_pipe (INT_W=32 and INT_W=16 instances); expected results
// are queued at acceptance and checked in order as results are handed off.
module tb_fcvt_pipe;
    logic        clk = 1'b0;
    logic        rstn, in_valid, in_op, in_rm, out_ready;
    logic [31:0] in_data;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, out_nx, out_nv;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        in_valid16, out_ready16, in_ready16, out_valid16, out_nx16, out_nv16;
    logic [31:0] out_data16;
    logic [4:0]  out_tag16;

    typedef struct packed { logic [31:0] d; logic [4:0] t; logic nx; logic nv; } res_t;
    res_t q32[$];
    res_t q16[$];
    int compared = 0, mismatched = 0, cyc = 0, first_acc = -1;
    logic [31:0] snap_d;
    logic [4:0]  snap_t;
    logic [1:0]  snap_f;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fcvt_pipe #(.INT_W(32), .TAG_W(5)) u32 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rm(in_rm), .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_nx(out_nx),
        .out_nv(out_nv));

    fcvt_pipe #(.INT_W(16), .TAG_W(5)) u16 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid16), .in_ready(in_ready16), .in_op(in_op),
        .in_rm(in_rm), .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid16),
        .out_ready(out_ready16), .out_data(out_data16), .out_tag(out_tag16), .out_nx(out_nx16),
        .out_nv(out_nv16));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input logic w16, input logic op, input logic rm, input logic [31:0] d,
                        input logic [31:0] ed, input logic enx, input logic env);
        logic [4:0] t;
        int n;
        t = 5'($urandom_range(0, 31));
        n = 0;
        in_op = op; in_rm = rm; in_data = d; in_tag = t;
        if (w16) in_valid16 = 1'b1; else in_valid = 1'b1;
        @(negedge clk);
        while (!(w16 ? in_ready16 : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        compared++;
        assert ((w16 ? in_ready16 : in_ready) === 1'b1) else begin
            mismatched++;
            $error("FAIL accept tag %0d in_ready %b want 1", t, w16 ? in_ready16 : in_ready);
        end
        if (first_acc < 0) first_acc = cyc;
        @(posedge clk);
        if (w16) q16.push_back({ed, t, enx, env}); else q32.push_back({ed, t, enx, env});
        #1;
        in_valid = 1'b0;
        in_valid16 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            compared++;
            assert (q32.size() > 0) else begin
                mismatched++;
                $error("FAIL out32 unexpected result %h tag %0d want none", out_data, out_tag);
            end
            if (q32.size() > 0) begin
                compared++;
                assert ({out_data, out_tag, out_nx, out_nv} === q32[0]) else begin
                    mismatched++;
                    $error("FAIL out32 got d=%h t=%0d nx=%b nv=%b want d=%h t=%0d nx=%b nv=%b",
                           out_data, out_tag, out_nx, out_nv, q32[0].d, q32[0].t, q32[0].nx, q32[0].nv);
                end
                void'(q32.pop_front());
            end
        end
        if (rstn && out_valid16 && out_ready16) begin
            compared++;
            assert (q16.size() > 0) else begin
                mismatched++;
                $error("FAIL out16 unexpected result %h want none", out_data16);
            end
            if (q16.size() > 0) begin
                compared++;
                assert ({out_data16, out_tag16, out_nx16, out_nv16} === q16[0]) else begin
                    mismatched++;
                    $error("FAIL out16 got d=%h t=%0d nx=%b nv=%b want d=%h t=%0d nx=%b nv=%b",
                           out_data16, out_tag16, out_nx16, out_nv16, q16[0].d, q16[0].t, q16[0].nx, q16[0].nv);
                end
                void'(q16.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0; in_op = 1'b0; in_rm = 1'b0;
        in_data = '0; in_tag = '0; out_ready = 1'b1; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_tag", 32'(out_tag), 32'd0);
        chk("reset flags", 32'({out_nx, out_nv}), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // itof
        send(0, 0, 0, 32'd16777217, 32'h4B800000, 1, 0);
        send(0, 0, 0, 32'd16777219, 32'h4B800002, 1, 0);
        send(0, 0, 1, 32'd16777219, 32'h4B800001, 1, 0);
        send(0, 0, 0, 32'hFFFFFFFF, 32'hBF800000, 0, 0);
        send(0, 0, 0, 32'h80000000, 32'hCF000000, 0, 0);
        send(0, 0, 0, 32'h00000000, 32'h00000000, 0, 0);
        send(0, 0, 0, 32'h01FFFFFF, 32'h4C000000, 1, 0);
        // ftoi rounding
        send(0, 1, 0, 32'h40200000, 32'h00000002, 1, 0);
        send(0, 1, 1, 32'h40200000, 32'h00000002, 1, 0);
        send(0, 1, 0, 32'h40600000, 32'h00000004, 1, 0);
        send(0, 1, 0, 32'hBFC00000, 32'hFFFFFFFE, 1, 0);
        send(0, 1, 1, 32'hBFC00000, 32'hFFFFFFFF, 1, 0);
        send(0, 1, 0, 32'h3F400000, 32'h00000001, 1, 0);
        send(0, 1, 1, 32'h3F400000, 32'h00000000, 1, 0);
        send(0, 1, 0, 32'hBF000000, 32'h00000000, 1, 0);
        send(0, 1, 0, 32'h3E800000, 32'h00000000, 1, 0);
        send(0, 1, 0, 32'h00000001, 32'h00000000, 1, 0);
        send(0, 1, 0, 32'h80000000, 32'h00000000, 0, 0);
        send(0, 1, 0, 32'h3F800000, 32'h00000001, 0, 0);
        // ftoi saturation
        send(0, 1, 0, 32'h4F000000, 32'h7FFFFFFF, 0, 1);
        send(0, 1, 0, 32'hCF000000, 32'h80000000, 0, 0);
        send(0, 1, 0, 32'hCF000001, 32'h80000000, 0, 1);
        send(0, 1, 0, 32'h7FC00000, 32'h7FFFFFFF, 0, 1);
        send(0, 1, 0, 32'hFF800000, 32'h80000000, 0, 1);
        send(0, 1, 0, 32'h7F800000, 32'h7FFFFFFF, 0, 1);
        send(0, 1, 0, 32'h5F000000, 32'h7FFFFFFF, 0, 1);
        // INT_W = 16
        send(1, 1, 0, 32'h47000000, 32'h00007FFF, 0, 1);
        send(1, 1, 0, 32'hC7000000, 32'hFFFF8000, 0, 0);
        send(1, 0, 0, 32'h00018000, 32'hC7000000, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("drain32", 32'(q32.size()), 32'd0);
        chk("drain16", 32'(q16.size()), 32'd0);

        // backpressure: 6 mixed ops with output stalled
        out_ready = 1'b0;
        first_acc = -1;
        fork
            begin
                send(0, 0, 0, 32'd16777219, 32'h4B800002, 1, 0);
                send(0, 1, 0, 32'hBFC00000, 32'hFFFFFFFE, 1, 0);
                send(0, 1, 0, 32'h4F000000, 32'h7FFFFFFF, 0, 1);
                send(0, 0, 0, 32'hFFFFFFFF, 32'hBF800000, 0, 0);
                send(0, 1, 1, 32'h40600000, 32'h00000003, 1, 0);
                send(0, 0, 0, 32'h80000000, 32'hCF000000, 0, 0);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp out_valid", 32'(out_valid), 32'd1);
                chk("bp latency", 32'(cyc - first_acc), 32'd3);
                snap_d = out_data; snap_t = out_tag; snap_f = {out_nx, out_nv};
                repeat (5) begin
                    @(negedge clk);
                    chk("bp in_ready", 32'(in_ready), 32'd0);
                    chk("bp data stable", out_data, snap_d);
                    chk("bp tag stable", 32'(out_tag), 32'(snap_t));
                    chk("bp flags stable", 32'({out_nx, out_nv}), 32'(snap_f));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("bp drain", 32'(q32.size()), 32'd0);

        // reset with three ops in flight and the first one stalled at the output
        out_ready = 1'b0;
        send(0, 0, 0, 32'hFFFFFFFF, 32'hBF800000, 0, 0);
        send(0, 1, 0, 32'h40200000, 32'h00000002, 1, 0);
        send(0, 0, 0, 32'd16777217, 32'h4B800000, 1, 0);
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        q32.delete();
        @(posedge clk);
        #1;
        chk("mid reset out_valid", 32'(out_valid), 32'd0);
        chk("mid reset out_data", out_data, 32'd0);
        chk("mid reset out_tag", 32'(out_tag), 32'd0);
        chk("mid reset flags", 32'({out_nx, out_nv}), 32'd0);
        chk("mid reset in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post reset out_valid", 32'(out_valid), 32'd0);
        chk("post reset in_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
